ring_buff_drain: RTL

RING_BUFF_DRAIN -- requirements
Module: ring_buff_drain

---
 rtl/ring_buff_pkg.sv | 15 +
 rtl/skid_buff2.sv | 75 +++++++
 rtl/ring_buff_drain.sv | 104 ++++++++++
 3 files changed

// File: rtl/ring_buff_pkg.sv
// Shared types and constants for the ring-buffer drain engine.
// Read latency of the paired ring-buffer controller and the skid-buffer geometry live here.
package ring_buff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } drain_state_e;

    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = 2;

endpackage

// File: rtl/skid_buff2.sv
// Two-entry FIFO that absorbs read data while the downstream consumer stalls.
// The head entry is presented on o_data; a simultaneous write and pop keeps FIFO order.
module skid_buff2
    import ring_buff_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_write,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic [OCC_W-1:0]      o_occ
);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    logic [WIDTH_DATA-1:0] head_q, head_d;
    logic [WIDTH_DATA-1:0] tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  do_pop;

    assign do_pop = i_pop & (occ_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({i_write, do_pop})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = i_data;
                    occ_d  = occ_q + OCC_ONE;
                end else if (occ_q != OCC_FULL) begin
                    tail_d = i_data;
                    occ_d  = occ_q + OCC_ONE;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_ONE;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever remains.
                if (occ_q == OCC_ONE) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign o_valid = (occ_q != '0);
    assign o_data  = head_q;
    assign o_occ   = occ_q;

endmodule

// File: rtl/ring_buff_drain.sv
// Drains a burst of I_Len entries from a ring-buffer controller into a valid/ready stream.
// Reads are credit-limited so read data plus buffered data never exceed the skid buffer.
module ring_buff_drain
    import ring_buff_pkg::*;
#(
    parameter int unsigned NUM_ENTRY  = 16,
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_LEN  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Start,
    input  logic [WIDTH_LEN-1:0]  I_Len,
    input  logic                  I_Empty,
    input  logic [WIDTH_DATA-1:0] I_RData,
    output logic                  O_Re,
    output logic                  O_Valid,
    output logic [WIDTH_DATA-1:0] O_Data,
    input  logic                  I_Rdy,
    output logic                  O_Busy,
    output logic                  O_Done
);

    localparam int unsigned PEND_W = OCC_W + 1;
    localparam int unsigned CREDIT = (NUM_ENTRY < SKID_DEPTH) ? NUM_ENTRY : SKID_DEPTH;

    drain_state_e           state_q, state_d;
    logic [WIDTH_LEN-1:0]   remaining_q, remaining_d;
    logic [RD_LATENCY-1:0]  inflight_q, inflight_d;

    logic                   skid_valid;
    logic [OCC_W-1:0]       skid_occ;
    logic                   pop_c;
    logic [PEND_W-1:0]      pend_c;
    logic                   rd_en_c;

    assign pop_c = skid_valid & I_Rdy;

    // Slots committed after this edge: buffered words not leaving now plus reads still in flight.
    assign pend_c = PEND_W'(skid_occ) - PEND_W'(pop_c) + PEND_W'($countones(inflight_q));

    assign rd_en_c = (state_q == ST_RUN) & ~I_Empty & (remaining_q != '0)
                   & (pend_c < PEND_W'(CREDIT));

    assign inflight_d = RD_LATENCY'({inflight_q, rd_en_c});

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_IDLE: begin
                if (I_Start) begin
                    remaining_d = I_Len;
                    state_d     = (I_Len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_en_c) begin
                    remaining_d = remaining_q - WIDTH_LEN'(1);
                end
                if ((remaining_q == '0) && (pend_c == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    skid_buff2 #(
        .WIDTH_DATA (WIDTH_DATA)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_write (inflight_q[RD_LATENCY-1]),
        .i_data  (I_RData),
        .i_pop   (pop_c),
        .o_valid (skid_valid),
        .o_data  (O_Data),
        .o_occ   (skid_occ)
    );

    assign O_Re    = rd_en_c;
    assign O_Valid = skid_valid;
    assign O_Busy  = (state_q != ST_IDLE);
    assign O_Done  = (state_q == ST_DONE);

endmodule
